// File: rtl/incr_pipeline_elastic.sv
// Elastic N-stage "x + INCR" pipeline with per-stage ready/valid and occupancy count.
// Optional macro RESET_DATA_PATH_EN: also clears the data registers on reset.
module incr_pipeline_elastic #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int INCR   = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             input_valid,
   output logic                             input_ready,
   input  logic [WIDTH-1:0]                 x,
   output logic                             output_valid,
   input  logic                             output_ready,
   output logic [WIDTH-1:0]                 out,
   output logic [$clog2(STAGES+1)-1:0]      occupancy
);

   localparam int               OCC_W  = $clog2(STAGES+1);
   localparam logic [WIDTH-1:0] INCR_W = WIDTH'(INCR);

   logic [STAGES-1:0] v_reg;
   logic [STAGES-1:0] v_next;
   logic [STAGES-1:0] load;
   logic [STAGES:0]   rdy;
   logic [WIDTH-1:0]  d_reg [STAGES];
   logic [WIDTH-1:0]  d_in  [STAGES];
   logic [OCC_W-1:0]  occ_reg;
   logic [OCC_W-1:0]  occ_next;

   // Ready ripples backwards: a stage can take a beat if it is empty or its successor moves.
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = output_ready;
      for (int i = STAGES - 1; i >= 0; i--) begin
         rdy[i] = ~v_reg[i] | rdy[i+1];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign v_next[gi] = rdy[gi] ? input_valid : v_reg[gi];
            assign load[gi]   = rdy[gi] & input_valid;
            assign d_in[gi]   = x;
         end else begin : g_body
            assign v_next[gi] = rdy[gi] ? v_reg[gi-1] : v_reg[gi];
            assign load[gi]   = rdy[gi] & v_reg[gi-1];
            if (gi == 1) begin : g_add
               assign d_in[gi] = d_reg[gi-1] + INCR_W;
            end else begin : g_pass
               assign d_in[gi] = d_reg[gi-1];
            end
         end
      end
   endgenerate

   // Occupancy is registered alongside v so both always describe the same edge.
   always_comb begin
      occ_next = '0;
      for (int i = 0; i < STAGES; i++) begin
         occ_next = occ_next + OCC_W'(v_next[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_reg   <= '0;
         occ_reg <= '0;
      end else begin
         v_reg   <= v_next;
         occ_reg <= occ_next;
      end
   end

`ifdef RESET_DATA_PATH_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            d_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            if (load[i]) begin
               d_reg[i] <= d_in[i];
            end
         end
      end
   end
`else
   // Data flops carry no reset; only accepted beats ever load them.
   always_ff @(posedge clk) begin
      for (int i = 0; i < STAGES; i++) begin
         if (load[i]) begin
            d_reg[i] <= d_in[i];
         end
      end
   end
`endif

   assign input_ready  = rdy[0];
   assign output_valid = v_reg[STAGES-1];
   assign out          = d_reg[STAGES-1];
   assign occupancy    = occ_reg;

endmodule
